// File: rtl/sound_pkg.sv
// Shared definitions for the sound arbiter: requester count, reset rate,
// default burst length and FSM state encodings.
package sound_pkg;

  localparam int NREQ          = 4;
  localparam int BURST_MAX_DEF = 4;
  localparam logic [15:0] RATE_RESET = 16'd1000;

  // IDLE picks a requester, PUSH issues one sample, GAP decides whether to continue.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sound_arb_rr_pick4.sv
// Combinational round-robin picker: first eligible index after 'last',
// searching last+1, last+2, last+3, last (all modulo 4).
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] index
);

  logic [1:0] cand [4];
  logic [3:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      // Candidate gi is the (gi+1)-th position after the last grant; wraps naturally in 2 bits.
      assign cand[gi] = last + 2'(gi + 1);
      assign hit[gi]  = eligible[cand[gi]];
    end
  endgenerate

  // Nearest hit to 'last' wins; iterate farthest-first so the nearest overrides.
  always_comb begin
    index = 2'd0;
    found = |hit;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) index = cand[k];
    end
  end

endmodule

// File: rtl/sound_arb.sv
// Sound FIFO arbiter: round-robin over four sample requesters, issuing bursts
// of up to BURST_MAX samples with a mandatory gap cycle between pushes.
module sound_arb
  import sound_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_sample,
  output logic [3:0]  req_ack,
  input  logic        cfg_we,
  input  logic [15:0] cfg_rate,
  input  logic [3:0]  cfg_en,
  output logic [15:0] sound_clr_sample,
  output logic        sound_clr_req,
  input  logic        sound_clr_full,
  output logic [15:0] sound_clr_rate,
  output logic [1:0]  grant_id
);

  arb_state_t  state_q;
  logic [3:0]  en_q;
  logic [1:0]  last_q;
  logic [1:0]  grant_q;
  logic [2:0]  count_q;

  logic [15:0] sample_w [NREQ];
  logic [3:0]  eligible;
  logic        pick_found;
  logic [1:0]  pick_index;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      // Requester gi owns a 16-bit lane of the flat sample bus.
      assign sample_w[gi] = req_sample[16*gi +: 16];
    end
  endgenerate

  // A requester competes only while it has data and is enabled by the registered mask.
  assign eligible = req_valid & en_q;
  assign grant_id = grant_q;

  rr_pick4 u_pick (
    .eligible (eligible),
    .last     (last_q),
    .found    (pick_found),
    .index    (pick_index)
  );

  // Arbitration FSM with registered strobes; reset wins over any push in the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      req_ack          <= 4'b0000;
      sound_clr_req    <= 1'b0;
      sound_clr_sample <= 16'd0;
      sound_clr_rate   <= RATE_RESET;
      en_q             <= 4'b1111;
      last_q           <= 2'd3;
      grant_q          <= 2'd0;
      count_q          <= 3'd0;
    end else begin
      req_ack       <= 4'b0000;
      sound_clr_req <= 1'b0;

      // Config takes effect next edge, so any decision this cycle still sees the old mask.
      if (cfg_we) begin
        sound_clr_rate <= cfg_rate;
        en_q           <= cfg_en;
      end

      case (state_q)
        ST_IDLE: begin
          if (!sound_clr_full && pick_found) begin
            grant_q <= pick_index;
            count_q <= 3'd0;
            state_q <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          // Once committed, a push completes even if the requester was disabled meanwhile.
          sound_clr_req    <= 1'b1;
          sound_clr_sample <= sample_w[grant_q];
          req_ack          <= 4'(1) << grant_q;
          count_q          <= count_q + 3'd1;
          state_q          <= ST_GAP;
        end
        ST_GAP: begin
          if ((count_q < 3'(BURST_MAX)) && eligible[grant_q] && !sound_clr_full) begin
            state_q <= ST_PUSH;
          end else begin
            last_q  <= grant_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_arb.sv
// Directed bench for sound_arb: burst-level reference model compared every
// cycle, plus literal expectations for timing, grant order and config effects.
module tb_sound_arb;

  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [63:0] req_sample = 64'd0;
  logic [3:0]  req_ack;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_rate = 16'd0;
  logic [3:0]  cfg_en = 4'b0000;
  logic [15:0] sound_clr_sample;
  logic        sound_clr_req;
  logic        sound_clr_full = 1'b0;
  logic [15:0] sound_clr_rate;
  logic [1:0]  grant_id;

  sound_arb #(.BURST_MAX(BM)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_sample       (req_sample),
    .req_ack          (req_ack),
    .cfg_we           (cfg_we),
    .cfg_rate         (cfg_rate),
    .cfg_en           (cfg_en),
    .sound_clr_sample (sound_clr_sample),
    .sound_clr_req    (sound_clr_req),
    .sound_clr_full   (sound_clr_full),
    .sound_clr_rate   (sound_clr_rate),
    .grant_id         (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Burst view: 'free' means waiting for a winner, 'due' means a sample is owed
  // next edge, 'owed_check' means a sample just went out and we decide whether
  // the owner may take another one.
  localparam int PH_FREE = 0, PH_DUE = 1, PH_CHECK = 2;

  int          m_phase;
  int          m_pushes;
  logic [1:0]  m_last;
  logic [3:0]  m_en;
  logic        exp_req;
  logic [3:0]  exp_ack;
  logic [15:0] exp_sample;
  logic [15:0] exp_rate;
  logic [1:0]  exp_grant;

  function automatic bit rr_found(input logic [3:0] elig);
    return elig != 4'b0000;
  endfunction

  function automatic logic [1:0] rr_index(input logic [1:0] last, input logic [3:0] elig);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (int'(last) + k) % 4;
      if (elig[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_phase <= PH_FREE; m_pushes <= 0; m_last <= 2'd3; m_en <= 4'b1111;
      exp_req <= 1'b0; exp_ack <= 4'b0; exp_sample <= 16'd0;
      exp_rate <= 16'd1000; exp_grant <= 2'd0;
    end else begin
      exp_req <= 1'b0;
      exp_ack <= 4'b0;
      if (cfg_we) begin
        exp_rate <= cfg_rate;
        m_en     <= cfg_en;
      end
      if (m_phase == PH_FREE) begin
        if (!sound_clr_full && rr_found(req_valid & m_en)) begin
          exp_grant <= rr_index(m_last, req_valid & m_en);
          m_pushes  <= 0;
          m_phase   <= PH_DUE;
        end
      end else if (m_phase == PH_DUE) begin
        exp_req    <= 1'b1;
        exp_sample <= req_sample[int'(exp_grant)*16 +: 16];
        exp_ack    <= 4'(1) << exp_grant;
        m_pushes   <= m_pushes + 1;
        m_phase    <= PH_CHECK;
      end else begin
        if (m_pushes < BM && req_valid[exp_grant] && m_en[exp_grant] && !sound_clr_full)
          m_phase <= PH_DUE;
        else begin
          m_last  <= exp_grant;
          m_phase <= PH_FREE;
        end
      end
    end
  end

  // ---------------- per-cycle compare and push log ----------------
  int   push_t[$];
  int   push_id[$];
  logic prev_req = 1'b0;

  function automatic int ack_idx(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("req",    64'(sound_clr_req),    64'(exp_req));
      chk("ack",    64'(req_ack),          64'(exp_ack));
      chk("sample", 64'(sound_clr_sample), 64'(exp_sample));
      chk("rate",   64'(sound_clr_rate),   64'(exp_rate));
      chk("grant",  64'(grant_id),         64'(exp_grant));
      chk("b2b",    64'(prev_req & sound_clr_req), 64'd0);
      prev_req <= sound_clr_req;
      if (sound_clr_req) begin
        push_t.push_back(cyc);
        push_id.push_back(ack_idx(req_ack));
        $display("push cyc=%0d id=%0d sample=%h", cyc, ack_idx(req_ack), sound_clr_sample);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base, m, ok, cnt1;
    int t1_exp[5];
    int ord[5];
    int cnt[4];
    t1_exp = '{2, 4, 6, 8, 11};
    ord    = '{0, 1, 2, 3, 0};

    // Reset values
    rst = 1'b0;
    tick(3); #1;
    chk("rst_req",   64'(sound_clr_req),    64'd0);
    chk("rst_ack",   64'(req_ack),          64'd0);
    chk("rst_smp",   64'(sound_clr_sample), 64'd0);
    chk("rst_rate",  64'(sound_clr_rate),   64'd1000);
    chk("rst_grant", 64'(grant_id),         64'd0);

    // Single requester: pushes every other cycle, then one idle cycle between bursts
    push_t.delete(); push_id.delete();
    base = cyc; rst = 1'b1; req_valid = 4'b0001; req_sample = 64'h1234;
    tick(14); #1;
    chk("t1_npush_ge5", 64'(push_t.size() >= 5), 64'd1);
    for (int k = 0; k < 5; k++)
      if (k < push_t.size()) chk("t1_push_time", 64'(push_t[k] - base), 64'(t1_exp[k]));
    req_valid = 4'b0000; rst = 1'b0; tick(2);

    // All requesters valid: full round robin with equal burst lengths
    push_t.delete(); push_id.delete();
    base = cyc; rst = 1'b1; req_valid = 4'b1111;
    req_sample = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    tick(48); #1;
    chk("t2_npush_ge20", 64'(push_t.size() >= 20), 64'd1);
    cnt = '{0, 0, 0, 0};
    for (int k = 0; k < 20; k++) begin
      if (k < push_id.size()) begin
        chk("t2_order", 64'(push_id[k]), 64'(ord[k / 4]));
        if (k < 16 && push_id[k] >= 0) cnt[push_id[k]]++;
      end
    end
    for (int i = 0; i < 4; i++) chk("t2_ackcnt", 64'(cnt[i]), 64'd4);
    if (push_t.size() > 4) chk("t2_burst2_time", 64'(push_t[4] - base), 64'd11);
    req_valid = 4'b0000; rst = 1'b0; tick(2);

    // FIFO full during the second gap: burst released, resumes after full drops
    push_t.delete(); push_id.delete();
    base = cyc; rst = 1'b1; req_valid = 4'b0001; req_sample = 64'hBEEF;
    tick(4); sound_clr_full = 1'b1;
    tick(6); sound_clr_full = 1'b0; m = cyc;
    tick(3); #1;
    chk("t3_npush_ge3", 64'(push_t.size() >= 3), 64'd1);
    if (push_t.size() >= 3) begin
      chk("t3_p0", 64'(push_t[0] - base), 64'd2);
      chk("t3_p1", 64'(push_t[1] - base), 64'd4);
      chk("t3_resume", 64'(push_t[2] - m), 64'd2);
    end
    req_valid = 4'b0000; rst = 1'b0; tick(2);

    // Disable requester 1 while it holds the grant; new rate appears next cycle
    push_t.delete(); push_id.delete();
    rst = 1'b1; req_valid = 4'b0011;
    req_sample = {16'h0, 16'h0, 16'hB001, 16'hB000};
    ok = 0;
    for (int w = 0; w < 40 && ok == 0; w++) begin
      tick(1);
      if (grant_id == 2'd1) ok = 1;
    end
    chk("t4_grant1_seen", 64'(ok), 64'd1);
    cfg_we = 1'b1; cfg_en = 4'b1101; cfg_rate = 16'd500;
    tick(1); cfg_we = 1'b0; #1;
    chk("t4_rate500", 64'(sound_clr_rate), 64'd500);
    tick(30); #1;
    cnt1 = 0;
    foreach (push_id[k]) if (push_id[k] == 1) cnt1++;
    chk("t4_req1_pushes", 64'(cnt1), 64'd1);
    if (push_id.size() > 0) chk("t4_last_id", 64'(push_id[push_id.size()-1]), 64'd0);
    req_valid = 4'b0000; tick(3);

    // Reset during a PUSH cycle cancels the push; first grant afterwards is requester 0
    push_t.delete(); push_id.delete();
    req_valid = 4'b0100; req_sample = {16'h0, 16'hC002, 16'h0, 16'hC000};
    ok = 0;
    for (int w = 0; w < 20 && ok == 0; w++) begin
      tick(1); #1;
      if (push_t.size() > 0) ok = 1;
    end
    chk("t5_push_seen", 64'(ok), 64'd1);
    tick(1); rst = 1'b0;
    tick(1); #1;
    chk("t5_req0",   64'(sound_clr_req),  64'd0);
    chk("t5_ack0",   64'(req_ack),        64'd0);
    chk("t5_rate",   64'(sound_clr_rate), 64'd1000);
    chk("t5_npush",  64'(push_t.size()),  64'd1);
    req_valid = 4'b0101; rst = 1'b1;
    tick(3); #1;
    chk("t5_npush2", 64'(push_id.size() >= 2), 64'd1);
    if (push_id.size() >= 2) chk("t5_first_id", 64'(push_id[1]), 64'd0);
    req_valid = 4'b0000; tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
